// File: rtl/call_ret_ctrl.sv
// Return-address-stack initiator: turns decoded CALL/RET into stack push/pop and fetch PC loads.
// CALL: push + pc_load one cycle after acceptance; RET: pop at +1, pc_load at +3; cmd_ready only in IDLE.
module call_ret_ctrl #(
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 12,
  parameter int PTR_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_target,
  input  logic [ADDR_W-1:0] pc_cur,
  output logic              stk_push_en,
  output logic              stk_pop_en,
  output logic [PTR_W-1:0]  stk_addr,
  output logic [ADDR_W-1:0] stk_wdata,
  input  logic [ADDR_W-1:0] stk_rdata,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_next,
  output logic [PTR_W-1:0]  depth,
  output logic              err_ovf,
  output logic              err_udf,
  input  logic              err_clr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALL_PUSH,
    S_RET_POP,
    S_RET_WAIT,
    S_RET_LOAD
  } state_t;

  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
  localparam logic [1:0]       OP_CALL = 2'b01;
  localparam logic [1:0]       OP_RET  = 2'b10;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    depth_q, depth_d;
  logic [PTR_W-1:0]    addr_q, addr_d;
  logic [ADDR_W-1:0]   wdata_q, wdata_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                ovf_q, ovf_d;
  logic                udf_q, udf_d;

  logic accept, is_call, is_ret, full, empty, call_ok, ret_ok;

  assign accept  = cmd_valid && (state_q == S_IDLE);
  assign is_call = accept && (cmd_op == OP_CALL);
  assign is_ret  = accept && (cmd_op == OP_RET);
  assign full    = (depth_q == DEPTH_P);
  assign empty   = (depth_q == '0);
  assign call_ok = is_call && !full;
  assign ret_ok  = is_ret && !empty;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      depth_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      pc_q    <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      pc_q    <= pc_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (call_ok)     state_d = S_CALL_PUSH;
        else if (ret_ok) state_d = S_RET_POP;
      end
      S_CALL_PUSH: state_d = S_IDLE;
      S_RET_POP:   state_d = S_RET_WAIT;
      S_RET_WAIT:  state_d = S_RET_LOAD;
      S_RET_LOAD:  state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Address/data are latched at acceptance so they are stable during the enable cycle
  // and simply hold afterwards; pc_q doubles as CALL target and RET read-back holder.
  always_comb begin
    depth_d = depth_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    pc_d    = pc_q;
    if (state_q == S_CALL_PUSH) depth_d = depth_q + PTR_W'(1);
    if (state_q == S_RET_POP)   depth_d = depth_q - PTR_W'(1);
    if (call_ok) begin
      addr_d  = depth_q;
      wdata_d = pc_cur + ADDR_W'(1);
      pc_d    = cmd_target;
    end
    if (ret_ok) addr_d = depth_q - PTR_W'(1);
    if (state_q == S_RET_WAIT) pc_d = stk_rdata;
    ovf_d = (ovf_q && !err_clr) || (is_call && full);
    udf_d = (udf_q && !err_clr) || (is_ret && empty);
  end

  // Output logic
  always_comb begin
    cmd_ready   = (state_q == S_IDLE);
    stk_push_en = (state_q == S_CALL_PUSH);
    stk_pop_en  = (state_q == S_RET_POP);
    pc_load     = (state_q == S_CALL_PUSH) || (state_q == S_RET_LOAD);
  end

  assign stk_addr  = addr_q;
  assign stk_wdata = wdata_q;
  assign pc_next   = pc_q;
  assign depth     = depth_q;
  assign err_ovf   = ovf_q;
  assign err_udf   = udf_q;

endmodule

// File: tb/tb_call_ret_ctrl.sv
// Bench for call_ret_ctrl: directed vector table, reset-abort sequence and randomized commands
// checked against a queue-based return-stack model with a registered-read stack array.
module tb_call_ret_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [13:0] cmd_target = '0;
  logic [13:0] pc_cur = '0;
  logic        stk_push_en, stk_pop_en;
  logic [3:0]  stk_addr;
  logic [13:0] stk_wdata;
  logic [13:0] stk_rdata;
  logic        pc_load;
  logic [13:0] pc_next;
  logic [3:0]  depth;
  logic        err_ovf, err_udf;
  logic        err_clr = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  call_ret_ctrl #(.ADDR_W(14), .DEPTH(12), .PTR_W(4)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_target(cmd_target), .pc_cur(pc_cur),
    .stk_push_en(stk_push_en), .stk_pop_en(stk_pop_en), .stk_addr(stk_addr),
    .stk_wdata(stk_wdata), .stk_rdata(stk_rdata), .pc_load(pc_load), .pc_next(pc_next),
    .depth(depth), .err_ovf(err_ovf), .err_udf(err_udf), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Stack array: plain register file with registered read
  logic [13:0] mem [16];
  always @(posedge clk) begin
    if (stk_push_en) mem[stk_addr] <= stk_wdata;
    if (stk_pop_en)  stk_rdata <= mem[stk_addr];
  end

  // Reference model: return addresses as a LIFO queue
  logic [13:0] m_stk[$];
  bit          m_ovf, m_udf;
  logic [3:0]  m_addr;
  logic [13:0] m_wdata;

  typedef struct {
    logic [1:0]  op;
    logic [13:0] tgt;
    logic [13:0] pc;
    logic        clr;
    int          dep;
    logic        ovf;
    logic        udf;
    logic        ld;
    logic [13:0] pcx;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [1:0] op, input logic [13:0] tgt, input logic [13:0] pc,
                     input logic clr, input int dep, input logic ovf, input logic udf,
                     input logic ld, input logic [13:0] pcx);
    vec_t v;
    v.op = op; v.tgt = tgt; v.pc = pc; v.clr = clr; v.dep = dep;
    v.ovf = ovf; v.udf = udf; v.ld = ld; v.pcx = pcx;
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_stk.delete();
    m_ovf = 0; m_udf = 0; m_addr = '0; m_wdata = '0;
    check("reset_outputs",
          {cmd_ready, stk_push_en, stk_pop_en, pc_load, stk_addr, stk_wdata, pc_next, depth, err_ovf, err_udf},
          {1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 14'h0, 14'h0, 4'h0, 1'b0, 1'b0});
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic run_cmd(input logic [1:0] op, input logic [13:0] tgt, input logic [13:0] pc,
                         input logic clr, output logic got_ld, output logic [13:0] got_pc);
    bit          ok_call, ok_ret, e_push, e_pop, e_load, e_ready;
    logic [13:0] exp_pc;
    int          dep0;
    dep0    = m_stk.size();
    ok_call = (op == 2'b01) && (dep0 < 12);
    ok_ret  = (op == 2'b10) && (dep0 > 0);
    exp_pc  = tgt;
    got_ld  = 1'b0;
    got_pc  = '0;
    check("ready_before_cmd", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_op = op; cmd_target = tgt; pc_cur = pc; err_clr = clr;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0; err_clr = 1'b0;
    cmd_op = 2'($urandom_range(0, 3)); cmd_target = 14'($urandom); pc_cur = 14'($urandom);
    m_ovf = (m_ovf && !clr) || (op == 2'b01 && dep0 == 12);
    m_udf = (m_udf && !clr) || (op == 2'b10 && dep0 == 0);
    if (ok_call) begin
      m_addr  = 4'(dep0);
      m_wdata = pc + 14'd1;
      m_stk.push_back(m_wdata);
    end
    if (ok_ret) begin
      m_addr = 4'(dep0 - 1);
      exp_pc = m_stk.pop_back();
    end
    for (int k = 1; k <= 4; k++) begin
      e_push  = ok_call && k == 1;
      e_pop   = ok_ret && k == 1;
      e_load  = (ok_call && k == 1) || (ok_ret && k == 3);
      e_ready = ok_call ? (k >= 2) : ok_ret ? (k >= 4) : 1'b1;
      check($sformatf("cycle%0d_op%0d", k, op),
            {cmd_ready, stk_push_en, stk_pop_en, pc_load, stk_addr, stk_wdata, (e_load ? pc_next : 14'h0)},
            {e_ready, e_push, e_pop, e_load, m_addr, m_wdata, (e_load ? exp_pc : 14'h0)});
      if (pc_load) begin
        got_ld = 1'b1;
        got_pc = pc_next;
      end
      if (k < 4) @(negedge clk);
    end
    check("depth_flags", {depth, err_ovf, err_udf}, {4'(m_stk.size()), m_ovf, m_udf});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        gl;
    logic [13:0] gp;
    int          r;
    logic [1:0]  op;

    // Directed vectors
    add(2'b01, 14'h0200, 14'h0100, 1'b0, 1, 1'b0, 1'b0, 1'b1, 14'h0200);
    add(2'b10, 14'h0000, 14'h0000, 1'b0, 0, 1'b0, 1'b0, 1'b1, 14'h0101);
    for (int i = 0; i < 12; i++)
      add(2'b01, 14'h1000 + 14'(i), 14'(i), 1'b0, i + 1, 1'b0, 1'b0, 1'b1, 14'h1000 + 14'(i));
    add(2'b01, 14'h2000, 14'h0055, 1'b0, 12, 1'b1, 1'b0, 1'b0, 14'h0);
    for (int i = 11; i >= 0; i--)
      add(2'b10, 14'h0, 14'h0, 1'b0, i, 1'b1, 1'b0, 1'b1, 14'(i + 1));
    add(2'b10, 14'h0, 14'h0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 14'h0);
    add(2'b00, 14'h0, 14'h0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 14'h0);
    add(2'b10, 14'h0, 14'h0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 14'h0);
    add(2'b01, 14'h0123, 14'h3FFF, 1'b0, 1, 1'b0, 1'b1, 1'b1, 14'h0123);
    add(2'b00, 14'h0456, 14'h0789, 1'b0, 1, 1'b0, 1'b1, 1'b0, 14'h0);
    add(2'b11, 14'h0456, 14'h0789, 1'b0, 1, 1'b0, 1'b1, 1'b0, 14'h0);
    add(2'b10, 14'h0, 14'h0, 1'b0, 0, 1'b0, 1'b1, 1'b1, 14'h0000);

    do_reset();
    foreach (tbl[i]) begin
      run_cmd(tbl[i].op, tbl[i].tgt, tbl[i].pc, tbl[i].clr, gl, gp);
      check($sformatf("tbl%0d_state", i), {32'(depth), err_ovf, err_udf, gl},
            {32'(tbl[i].dep), tbl[i].ovf, tbl[i].udf, tbl[i].ld});
      if (tbl[i].ld) check($sformatf("tbl%0d_pc", i), gp, tbl[i].pcx);
    end

    // Reset while the RET read is in flight
    do_reset();
    run_cmd(2'b10, 14'h0, 14'h0, 1'b0, gl, gp);
    run_cmd(2'b01, 14'h0AAA, 14'h0010, 1'b0, gl, gp);
    run_cmd(2'b01, 14'h0BBB, 14'h0020, 1'b0, gl, gp);
    cmd_valid = 1'b1; cmd_op = 2'b10;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = 2'b00;
    check("abort_pop", {stk_pop_en, stk_addr, cmd_ready}, {1'b1, 4'd1, 1'b0});
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("abort_idle", {cmd_ready, depth, pc_load, err_ovf, err_udf, stk_push_en, stk_pop_en},
          {1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    check("abort_no_load", {pc_load, depth}, {1'b0, 4'd0});
    m_stk.delete();
    m_ovf = 0; m_udf = 0; m_addr = '0; m_wdata = '0;

    // Randomized: fill-biased phase, then drain-biased phase
    do_reset();
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      op = (n < 200) ? 2'b01 : 2'b10;
      else if (r < 8) op = (n < 200) ? 2'b10 : 2'b01;
      else            op = (r == 8) ? 2'b00 : 2'b11;
      run_cmd(op, 14'($urandom), 14'($urandom), ($urandom_range(0, 7) == 0), gl, gp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
